fp32_adder: RTL and testbench

//  IEEE-754 binary32 adder: s = a + b, round-to-nearest-even, full special-value handling.

---
 rtl/fp32_adder.sv | 134 +++++++++++++
 tb/tb_fp32_adder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fp32_adder.sv
// IEEE-754 binary32 adder, round-to-nearest-even, with full special-value and subnormal support.
// The sum is computed combinationally from a and b and registered once per clock.
module fp32_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [31:0] opnd [2];
  logic [1:0]  is_nan;
  logic [1:0]  is_inf;

  assign opnd[0] = a;
  assign opnd[1] = b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_class
      assign is_inf[gi] = (opnd[gi][30:23] == 8'hFF) && (opnd[gi][22:0] == 23'd0);
      assign is_nan[gi] = (opnd[gi][30:23] == 8'hFF) && (opnd[gi][22:0] != 23'd0);
    end
  endgenerate

  // Raw {exp,frac} bits order the same way as magnitudes, so one compare picks the larger operand.
  logic        a_big;
  logic        big_sign;
  logic [30:0] big_mag;
  logic [30:0] small_mag;
  logic [7:0]  big_exp;
  logic [7:0]  small_exp;
  logic [23:0] big_man;
  logic [23:0] small_man;
  logic [7:0]  exp_diff;
  logic [4:0]  shift_amt;
  logic [51:0] small_wide;
  logic [26:0] big_ext;
  logic [26:0] small_ext;
  logic        eff_sub;
  logic [27:0] sum;

  assign a_big     = (a[30:0] >= b[30:0]);
  assign big_sign  = a_big ? a[31] : b[31];
  assign big_mag   = a_big ? a[30:0] : b[30:0];
  assign small_mag = a_big ? b[30:0] : a[30:0];

  assign big_exp   = (big_mag[30:23] == 8'd0) ? 8'd1 : big_mag[30:23];
  assign small_exp = (small_mag[30:23] == 8'd0) ? 8'd1 : small_mag[30:23];
  assign big_man   = {|big_mag[30:23], big_mag[22:0]};
  assign small_man = {|small_mag[30:23], small_mag[22:0]};

  assign exp_diff  = big_exp - small_exp;
  assign shift_amt = (exp_diff > 8'd26) ? 5'd26 : exp_diff[4:0];

  // Upper 26 bits form mantissa+G+R; everything falling below them collapses into sticky.
  assign small_wide = {small_man, 28'd0} >> shift_amt;
  assign small_ext  = {small_wide[51:26], |small_wide[25:0]};
  assign big_ext    = {big_man, 3'b000};

  assign eff_sub = a[31] ^ b[31];
  assign sum     = eff_sub ? ({1'b0, big_ext} - {1'b0, small_ext})
                           : ({1'b0, big_ext} + {1'b0, small_ext});

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  logic [4:0]  lz;
  logic [4:0]  shl;
  logic [7:0]  shl_limit;
  logic [26:0] norm;
  logic [8:0]  norm_exp;
  logic [8:0]  res_exp;
  logic [24:0] mant;
  logic        round_up;
  logic [22:0] res_frac;

  always_comb begin
    lz        = lzc27(sum[26:0]);
    // Left shift stops at effective exponent 1; anything still unnormalised becomes subnormal.
    shl_limit = big_exp - 8'd1;
    shl       = ({3'd0, lz} < shl_limit) ? lz : shl_limit[4:0];
    if (sum[27]) begin
      norm     = {sum[27:2], sum[1] | sum[0]};
      norm_exp = {1'b0, big_exp} + 9'd1;
    end else begin
      norm     = sum[26:0] << shl;
      norm_exp = {1'b0, big_exp} - {4'd0, shl};
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant     = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (mant[24]) begin
      res_exp  = norm_exp + 9'd1;
      res_frac = mant[23:1];
    end else begin
      // A subnormal that rounds up into bit 23 lands on exponent 1 automatically.
      res_exp  = mant[23] ? norm_exp : 9'd0;
      res_frac = mant[22:0];
    end
  end

  logic [31:0] sum_next;

  always_comb begin
    sum_next = 32'd0;
    if ((is_nan != 2'b00) || ((&is_inf) && (a[31] != b[31]))) begin
      sum_next = QNAN;
    end else if (is_inf[0]) begin
      sum_next = a;
    end else if (is_inf[1]) begin
      sum_next = b;
    end else if (sum == 28'd0) begin
      sum_next = {a[31] & b[31], 31'd0};
    end else if (res_exp >= 9'd255) begin
      sum_next = {big_sign, 8'hFF, 23'd0};
    end else begin
      sum_next = {big_sign, res_exp[7:0], res_frac};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s <= 32'd0;
    end else begin
      s <= sum_next;
    end
  end
endmodule

// File: tb/tb_fp32_adder.sv
// Self-checking bench for fp32_adder: directed vector table, reset sequences, and random pairs
// compared against an exact-integer reference adder.
module tb_fp32_adder;
  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] s;

  int checks;
  int errors;

  fp32_adder dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .s(s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  // Exact value of a finite operand in units of 2^-149 (smallest subnormal).
  function automatic logic [299:0] magnitude(input logic [31:0] x);
    logic [299:0] v;
    v = {276'd0, (x[30:23] != 8'd0), x[22:0]};
    if (x[30:23] != 8'd0) v = v << (x[30:23] - 8'd1);
    return v;
  endfunction

  // Reference: exact integer sum, then round-to-nearest-even on the exact value.
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic         x_nan, y_nan, x_inf, y_inf, sg;
    logic [299:0] mx, my, m, keep, rem, half;
    int           p, sh, e;
    x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    if (x_nan || y_nan) return 32'h7FC00000;
    if (x_inf && y_inf) return (x[31] == y[31]) ? x : 32'h7FC00000;
    if (x_inf) return x;
    if (y_inf) return y;
    mx = magnitude(x);
    my = magnitude(y);
    if (x[31] == y[31]) begin
      m = mx + my; sg = x[31];
    end else if (mx >= my) begin
      m = mx - my; sg = x[31];
    end else begin
      m = my - mx; sg = y[31];
    end
    if (m == 0) return {x[31] & y[31], 31'd0};
    p = -1;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    if (p <= 23) return {sg, m[30:0]};
    sh   = p - 23;
    keep = m >> sh;
    rem  = m - (keep << sh);
    half = 300'd1 << (sh - 1);
    if ((rem > half) || ((rem == half) && keep[0])) keep = keep + 1;
    if (keep[24]) begin
      keep = keep >> 1;
      sh   = sh + 1;
    end
    e = sh + 1;
    if (e >= 255) return {sg, 8'hFF, 23'd0};
    return {sg, e[7:0], keep[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_s);
    checks++;
    if (got !== exp_s) begin
      errors++;
      $display("FAIL %s: a=%h b=%h got s=%h expected s=%h", name, a, b, got, exp_s);
    end
  endtask

  task automatic apply(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] exp_s,
                       input string name, input bit verbose);
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    if (verbose) $display("%s: a=%h b=%h s=%h expect %h", name, av, bv, s, exp_s);
    check(name, s, exp_s);
  endtask

  function automatic logic [31:0] rand_operand(input int kind, input logic [31:0] other);
    logic [31:0] r;
    int          e;
    r = $urandom;
    case (kind)
      0: return r;
      1: begin
        e = int'(other[30:23]) + int'($urandom_range(0, 4)) - 2;
        if (e < 0) e = 0;
        if (e > 254) e = 254;
        return {r[31], 8'(e), r[22:0]};
      end
      2: return {r[31], 8'($urandom_range(0, 2)), r[22:0]};
      default: begin
        case ($urandom_range(0, 3))
          0: e = 0;
          1: e = 255;
          2: e = 254;
          default: e = 1;
        endcase
        if ($urandom_range(0, 1) == 0) r[22:0] = 23'd0;
        return {r[31], 8'(e), r[22:0]};
      end
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    int          kind;
    checks = 0;
    errors = 0;

    vecs = '{
      '{32'h3F800000, 32'h3F800000, 32'h40000000},
      '{32'h40490FDB, 32'hBF800000, 32'h40090FDB},
      '{32'h3F800000, 32'hBF800000, 32'h00000000},
      '{32'h80000000, 32'h80000000, 32'h80000000},
      '{32'h00000000, 32'h80000000, 32'h00000000},
      '{32'h3F800000, 32'h33800000, 32'h3F800000},
      '{32'h3F800001, 32'h33800000, 32'h3F800002},
      '{32'h3F800000, 32'hB3800000, 32'h3F7FFFFF},
      '{32'h4B800000, 32'h3F800000, 32'h4B800000},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
      '{32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000},
      '{32'h7F800000, 32'hFF800000, 32'h7FC00000},
      '{32'h7FC00001, 32'h3F800000, 32'h7FC00000},
      '{32'h3F800000, 32'h7F800001, 32'h7FC00000},
      '{32'hFF800000, 32'h3F800000, 32'hFF800000},
      '{32'h7F800000, 32'h7F800000, 32'h7F800000},
      '{32'h00000001, 32'h00000001, 32'h00000002},
      '{32'h00800000, 32'h80000001, 32'h007FFFFF},
      '{32'h007FFFFF, 32'h00000001, 32'h00800000},
      '{32'h00000003, 32'h00000000, 32'h00000003},
      '{32'h80000005, 32'h00000000, 32'h80000005},
      '{32'hC0000000, 32'h3F800000, 32'hBF800000}
    };

    // Reset state with live operands on the inputs.
    rst = 1'b1;
    a   = 32'h3F800000;
    b   = 32'h3F800000;
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("reset_state: s=%h expect 00000000", s);
    check("reset_state", s, 32'h00000000);

    // First valid sum appears one cycle after reset drops.
    rst = 1'b0;
    apply(32'h3F800000, 32'h3F800000, 32'h40000000, "first_after_reset", 1'b1);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].s, $sformatf("vec%0d", i), 1'b1);
    end

    // Reset asserted for a single edge mid-stream overrides the in-flight sum.
    a   = 32'h40000000;
    b   = 32'h40000000;
    rst = 1'b1;
    @(posedge clk);
    #1;
    $display("mid_reset: s=%h expect 00000000", s);
    check("mid_reset", s, 32'h00000000);
    rst = 1'b0;
    apply(32'h40400000, 32'h3F800000, 32'h40800000, "post_reset", 1'b1);

    for (int i = 0; i < 10000; i++) begin
      kind = i % 4;
      ra = rand_operand(kind == 1 ? 0 : kind, 32'd0);
      rb = rand_operand(kind, ra);
      apply(ra, rb, ref_add(ra, rb), "rand_add", 1'b0);
      apply(ra, rb ^ 32'h80000000, ref_add(ra, rb ^ 32'h80000000), "rand_sub", 1'b0);
      if ((i + 1) % 2000 == 0) $display("random pairs done: %0d", i + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
